// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain
//  Description : Linear chain of STAGES payload registers with per-stage
//                stall and flush control, output backpressure, occupancy
//                reporting and saturating bubble / drop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                            CLOCK,
  input  logic                            RESET_N,
  input  logic [WIDTH-1:0]                IN_DATA,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [STAGES-1:0]               STALL_VEC,
  input  logic [STAGES-1:0]               FLUSH_VEC,
  output logic [WIDTH-1:0]                OUT_DATA,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [$clog2(STAGES+1)-1:0]     OCCUPANCY,
  output logic [15:0]                     BUBBLE_CNT,
  output logic [15:0]                     DROP_CNT
);

  localparam int          c_occ_w   = $clog2(STAGES + 1);
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  // Stage storage: index 0 is the youngest entry, STAGES-1 the oldest.
  logic [WIDTH-1:0]   data_q  [STAGES];
  logic [WIDTH-1:0]   data_d  [STAGES];
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_d;
  logic [15:0]        bubble_q;
  logic [15:0]        bubble_d;
  logic [15:0]        drop_q;
  logic [15:0]        drop_d;

  // Control decode
  logic               w_bp;
  logic [STAGES-1:0]  w_frozen;
  logic [STAGES-1:0]  w_flush_mask;
  logic               w_frz_acc;
  logic               w_fl_acc;
  logic               w_in_ready;

  // Statistics
  logic               w_bubble_ev;
  logic [c_occ_w-1:0] w_drop_n;
  logic [c_occ_w-1:0] w_occ;
  logic [16:0]        w_drop_sum;

  // Freeze and flush ranges: both extend from the highest set bit down to
  // stage 0, so they are built with a running OR from the oldest stage.
  always_comb begin
    w_bp         = valid_q[STAGES-1] & ~OUT_READY;
    w_frz_acc    = w_bp;
    w_fl_acc     = 1'b0;
    w_frozen     = '0;
    w_flush_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_frz_acc       = w_frz_acc | STALL_VEC[i];
      w_fl_acc        = w_fl_acc  | FLUSH_VEC[i];
      w_frozen[i]     = w_frz_acc;
      w_flush_mask[i] = w_fl_acc;
    end
  end

  // Stage 0 accepts only when it is free to move and no flush is active,
  // so an input offered during a flush can never complete a handshake.
  always_comb begin
    w_in_ready = ~w_frozen[0] & ~(|FLUSH_VEC);
  end

  // Next-state for every stage: flush beats freeze, freeze beats load; a
  // stage that moves while its upstream neighbour is frozen takes a bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (w_flush_mask[0]) begin
      valid_d[0] = 1'b0;
    end else if (!w_frozen[0]) begin
      data_d[0]  = IN_DATA;
      valid_d[0] = IN_VALID & w_in_ready;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (w_flush_mask[i]) begin
        valid_d[i] = 1'b0;
      end else if (!w_frozen[i]) begin
        if (w_frozen[i-1]) begin
          valid_d[i] = 1'b0;
        end else begin
          data_d[i]  = data_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
      end
    end
  end

  // Bubble detection and per-cycle drop / occupancy population counts.
  always_comb begin
    w_bubble_ev = 1'b0;
    w_drop_n    = '0;
    w_occ       = '0;
    for (int i = 1; i < STAGES; i++) begin
      if (!w_flush_mask[i] && !w_frozen[i] && w_frozen[i-1]) begin
        w_bubble_ev = 1'b1;
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      w_drop_n = w_drop_n + c_occ_w'(valid_q[i] & w_flush_mask[i]);
      w_occ    = w_occ    + c_occ_w'(valid_q[i]);
    end
  end

  // Saturating counter updates.
  always_comb begin
    if (bubble_q == c_cnt_max) begin
      bubble_d = bubble_q;
    end else begin
      bubble_d = bubble_q + 16'(w_bubble_ev);
    end
    w_drop_sum = {1'b0, drop_q} + 17'(w_drop_n);
    drop_d     = w_drop_sum[16] ? c_cnt_max : w_drop_sum[15:0];
  end

  // State registers with synchronous active-low reset that wins over all
  // other inputs.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      valid_q  <= '0;
      bubble_q <= '0;
      drop_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
    end
  end

  assign IN_READY   = w_in_ready;
  assign OUT_DATA   = data_q[STAGES-1];
  assign OUT_VALID  = valid_q[STAGES-1];
  assign OCCUPANCY  = w_occ;
  assign BUBBLE_CNT = bubble_q;
  assign DROP_CNT   = drop_q;

endmodule
`default_nettype wire

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload bits per stage (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 4, meaning number of register stages (legal 2..8); stage 0 is youngest, stage STAGES-1 is oldest.
REQ-003 SHALL have port CLOCK  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_DATA  input  WIDTH  payload offered to stage 0.
REQ-006 SHALL have port IN_VALID  input  1  IN_DATA valid.
REQ-007 SHALL have port IN_READY  output  1  stage 0 accepts this cycle.
REQ-008 SHALL have port STALL_VEC  input  STAGES  bit k freezes stages 0..k.
REQ-009 SHALL have port FLUSH_VEC  input  STAGES  bit k invalidates stages 0..k.
REQ-010 SHALL have port OUT_DATA  output  WIDTH  payload of stage STAGES-1.
REQ-011 SHALL have port OUT_VALID  output  1  stage STAGES-1 valid.
REQ-012 SHALL have port OUT_READY  input  1  consumer takes OUT_DATA.
REQ-013 SHALL have port OCCUPANCY  output  clog2(STAGES+1)  count of valid stages.
REQ-014 SHALL have port BUBBLE_CNT  output  16  saturating count of stall-induced bubble cycles.
REQ-015 SHALL have port DROP_CNT  output  16  saturating count of valid entries killed by flush.

Function
REQ-016 SHALL compute backpressure BP = OUT_VALID & ~OUT_READY.
REQ-017 SHALL compute frozen[i] = BP | OR of STALL_VEC[j] for j>=i.
REQ-018 SHALL, for stage i not frozen, load data/valid from stage i-1 (stage 0: IN_DATA, IN_VALID&IN_READY).
REQ-019 SHALL, when stage i is not frozen and stage i-1 is frozen, load a bubble (valid=0, data held).
REQ-020 SHALL hold data and valid of every frozen stage.
REQ-021 SHALL drive IN_READY = ~frozen[0] & (FLUSH_VEC==0), combinationally.
REQ-022 SHALL, when FLUSH_VEC[k]=1, clear valid of stages 0..k next cycle; highest set bit defines range; flush overrides stall, hold and load.
REQ-023 SHALL let stages above the flush range advance/hold per REQ-017..020 in a flush cycle.
REQ-024 SHALL discard IN_DATA during any flush cycle (IN_READY=0 guarantees no handshake).
REQ-025 SHALL give latency STAGES cycles from accept to OUT_VALID with no stall, flush or backpressure; throughput one per cycle.
REQ-026 SHALL not apply backpressure when OUT_VALID=0 (tail bubble is overwritten).
REQ-027 SHALL drive OUT_DATA/OUT_VALID directly from stage STAGES-1 registers.
REQ-028 SHALL drive OCCUPANCY as popcount of stage valid registers.
REQ-029 SHALL increment BUBBLE_CNT by 1 in each cycle where at least one bubble per REQ-019 is inserted, saturating at 0xFFFF.
REQ-030 SHALL add to DROP_CNT the number of valid stages cleared by flush that cycle, saturating at 0xFFFF.
REQ-031 SHALL keep entries in strict order; no stage is ever skipped or duplicated.

Reset
REQ-032 SHALL, when RESET_N=0 at posedge, clear all valid bits, stage data, BUBBLE_CNT, DROP_CNT to 0, overriding all inputs including mid-stall/flush.
REQ-033 SHALL, during and after reset, present OUT_VALID=0, OUT_DATA=0, OCCUPANCY=0; IN_READY=1 in first cycle after RESET_N=1 absent flush.

Verification (WIDTH=32, STAGES=4)
REQ-034 SHALL cover: RESET_N=0 one cycle with IN_VALID=1, IN_DATA=0xDEAD -> OUT_VALID=0, OCCUPANCY=0, counters 0.
REQ-035 SHALL cover: 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, OUT_READY=1 -> 0xA0 at OUT on 4th posedge after accept, then A1..A3 back-to-back, OCCUPANCY peaks 4.
REQ-036 SHALL cover: full chain, STALL_VEC=4'b0010 one cycle -> stages 0,1 hold, stage 2 bubble, IN_READY=0, BUBBLE_CNT=1.
REQ-037 SHALL cover: full chain, FLUSH_VEC=4'b0100 -> stages 0..2 invalid, DROP_CNT=3, stage 3 entry still emitted, OCCUPANCY=1; with STALL_VEC=4'b0100 same cycle, result identical.
REQ-038 SHALL cover: OUT_VALID=1, OUT_READY=0 for 3 cycles -> OUT_DATA constant, IN_READY=0, no loss when OUT_READY returns to 1.
REQ-039 SHALL cover: 65540 bubble cycles -> BUBBLE_CNT=0xFFFF, then RESET_N=0 mid-stream -> all counters and valids 0 next cycle.
